// File: rtl/monochrome_pipe_pkg.sv
// monochrome_pipe_pkg: shared constants for the monochrome filter pipeline.
//   - Mode encodings (colour / green / amber / white phosphor).
//   - Luma coefficients 38/75/15 with a divide-by-128 shift.
//   - Fixed pixel latency.
//   - Ordered-dither offset table (used when MONOCHROME_DITHER_EN is defined).
// No ports.
package monochrome_pipe_pkg;

    localparam logic [1:0] MODE_COLOUR = 2'b00;
    localparam logic [1:0] MODE_GREEN  = 2'b01;
    localparam logic [1:0] MODE_AMBER  = 2'b10;
    localparam logic [1:0] MODE_WHITE  = 2'b11;

    localparam int unsigned COEF_R     = 38;
    localparam int unsigned COEF_G     = 75;
    localparam int unsigned COEF_B     = 15;
    localparam int unsigned LUMA_SHIFT = 7;

    localparam int unsigned LATENCY    = 3;

    // Dither offsets are below one luma LSB (128), so 7 bits hold them.
    localparam int unsigned DITHER_W   = 7;

    // 2x2 ordered-dither offset, indexed by {line_par, col_par}.
    function automatic logic [DITHER_W-1:0] dither_offset(input logic line_par,
                                                          input logic col_par);
        logic [DITHER_W-1:0] off;
        case ({line_par, col_par})
            2'b00:   off = 7'd0;
            2'b01:   off = 7'd64;
            2'b10:   off = 7'd96;
            default: off = 7'd32;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/monochrome_pipe_if.sv
// monochrome_pipe_if: pixel/sync bundle between the video source and the filter.
//   Source -> filter : mode_req, de_in, hs_in, vs_in, r_in, g_in, b_in
//   Filter -> sink   : r_out, g_out, b_out, de_out, hs_out, vs_out, mode_cur
// Modports: master (source/sink side), slave (the filter).
interface monochrome_pipe_if #(
    parameter int unsigned IN_BITS  = 3,
    parameter int unsigned OUT_BITS = 6
);

    logic [1:0]          mode_req;
    logic                de_in;
    logic                hs_in;
    logic                vs_in;
    logic [IN_BITS-1:0]  r_in;
    logic [IN_BITS-1:0]  g_in;
    logic [IN_BITS-1:0]  b_in;

    logic [OUT_BITS-1:0] r_out;
    logic [OUT_BITS-1:0] g_out;
    logic [OUT_BITS-1:0] b_out;
    logic                de_out;
    logic                hs_out;
    logic                vs_out;
    logic [1:0]          mode_cur;

    modport master (
        output mode_req, de_in, hs_in, vs_in, r_in, g_in, b_in,
        input  r_out, g_out, b_out, de_out, hs_out, vs_out, mode_cur
    );

    modport slave (
        input  mode_req, de_in, hs_in, vs_in, r_in, g_in, b_in,
        output r_out, g_out, b_out, de_out, hs_out, vs_out, mode_cur
    );

endinterface

// File: rtl/monochrome_pipe_luma.sv
// monochrome_pipe_luma: pipeline stage 2, weighted sum of expanded RGB to a
// registered luma value: luma = (r*38 + g*75 + b*15) >> 7.
// With MONOCHROME_DITHER_EN defined, a dither offset is added before the
// shift and the result saturates instead of wrapping.
// Ports:
//   clk, rst_n   pixel clock, synchronous active-low reset
//   r, g, b      expanded colour from stage 1 (OUT_BITS each)
//   dith         dither offset in sum LSBs (only with MONOCHROME_DITHER_EN)
//   luma         registered luma (OUT_BITS)
module monochrome_pipe_luma
    import monochrome_pipe_pkg::*;
#(
    parameter int unsigned OUT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OUT_BITS-1:0] r,
    input  logic [OUT_BITS-1:0] g,
    input  logic [OUT_BITS-1:0] b,
`ifdef MONOCHROME_DITHER_EN
    input  logic [DITHER_W-1:0] dith,
`endif
    output logic [OUT_BITS-1:0] luma
);

    localparam int unsigned SUM_W = OUT_BITS + LUMA_SHIFT;

    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_adj;
    logic [OUT_BITS-1:0] luma_d;
    logic [OUT_BITS-1:0] luma_q;

    // Coefficients sum to 128, so the result always fits in SUM_W bits.
    always_comb begin
        sum = SUM_W'(r) * SUM_W'(COEF_R)
            + SUM_W'(g) * SUM_W'(COEF_G)
            + SUM_W'(b) * SUM_W'(COEF_B);
    end

`ifdef MONOCHROME_DITHER_EN
    logic [SUM_W:0] sum_dith;

    always_comb begin
        sum_dith = {1'b0, sum} + (SUM_W + 1)'(dith);
        sum_adj  = sum_dith[SUM_W] ? {SUM_W{1'b1}} : sum_dith[SUM_W-1:0];
    end
`else
    always_comb begin
        sum_adj = sum;
    end
`endif

    always_comb begin
        luma_d = OUT_BITS'(sum_adj >> LUMA_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            luma_q <= '0;
        end else begin
            luma_q <= luma_d;
        end
    end

    assign luma = luma_q;

endmodule

// File: rtl/monochrome_pipe.sv
// monochrome_pipe: colour / monochrome-phosphor filter ahead of the video DAC.
//   S1: register inputs, expand IN_BITS -> OUT_BITS by bit replication.
//   S2: luma (monochrome_pipe_luma).
//   S3: mode mux and blanking, registered outputs.
// Fixed latency of 3 clocks; de/hs/vs are delayed to match.
// Mode is sampled on a vs_in rising edge and travels with each pixel, so a
// change never lands mid-frame.
// Optional macro MONOCHROME_DITHER_EN: 2x2 ordered dither in modes 01/10/11.
// Ports:
//   clk     pixel clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     monochrome_pipe_if slave: pixel/sync in, filtered pixel/sync out
module monochrome_pipe
    import monochrome_pipe_pkg::*;
#(
    parameter int unsigned IN_BITS  = 3,
    parameter int unsigned OUT_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    monochrome_pipe_if.slave  bus
);

    // Replicate the channel MSB-first and keep the top OUT_BITS bits.
    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        logic [OUT_BITS-1:0] e;
        for (int j = 0; j < int'(OUT_BITS); j++) begin
            e[int'(OUT_BITS) - 1 - j] = c[int'(IN_BITS) - 1 - (j % int'(IN_BITS))];
        end
        return e;
    endfunction

    logic                vs_prev_q;
    logic                vs_rise;
    logic [1:0]          mode_cur_q;
    logic [1:0]          mode_eff;

    logic [LATENCY-1:0]  de_sr_q;
    logic [LATENCY-1:0]  hs_sr_q;
    logic [LATENCY-1:0]  vs_sr_q;

    logic [OUT_BITS-1:0] s1_r_q, s1_g_q, s1_b_q;
    logic [1:0]          s1_mode_q;
    logic [OUT_BITS-1:0] s2_r_q, s2_g_q, s2_b_q;
    logic [1:0]          s2_mode_q;
    logic [OUT_BITS-1:0] s2_luma;

    logic [OUT_BITS-1:0] r_d, g_d, b_d;
    logic [OUT_BITS-1:0] r_out_q, g_out_q, b_out_q;

    assign vs_rise  = bus.vs_in & ~vs_prev_q;
    // The pixel sampled on the vs rise already uses the new mode.
    assign mode_eff = vs_rise ? bus.mode_req : mode_cur_q;

`ifdef MONOCHROME_DITHER_EN
    logic                de_prev_q;
    logic                col_par_q;
    logic                line_par_q;
    logic [DITHER_W-1:0] s1_dith_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_prev_q  <= 1'b0;
            col_par_q  <= 1'b0;
            line_par_q <= 1'b0;
            s1_dith_q  <= '0;
        end else begin
            de_prev_q <= bus.de_in;
            col_par_q <= bus.de_in ? ~col_par_q : 1'b0;
            if (vs_rise) begin
                line_par_q <= 1'b0;
            end else if (de_prev_q && !bus.de_in) begin
                line_par_q <= ~line_par_q;
            end
            s1_dith_q <= (mode_eff == MODE_COLOUR) ? '0
                                                   : dither_offset(line_par_q, col_par_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_prev_q  <= 1'b0;
            mode_cur_q <= MODE_COLOUR;
            de_sr_q    <= '0;
            hs_sr_q    <= '0;
            vs_sr_q    <= '0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_COLOUR;
            s2_r_q     <= '0;
            s2_g_q     <= '0;
            s2_b_q     <= '0;
            s2_mode_q  <= MODE_COLOUR;
            r_out_q    <= '0;
            g_out_q    <= '0;
            b_out_q    <= '0;
        end else begin
            vs_prev_q <= bus.vs_in;
            if (vs_rise) begin
                mode_cur_q <= bus.mode_req;
            end
            de_sr_q   <= {de_sr_q[LATENCY-2:0], bus.de_in};
            hs_sr_q   <= {hs_sr_q[LATENCY-2:0], bus.hs_in};
            vs_sr_q   <= {vs_sr_q[LATENCY-2:0], bus.vs_in};
            s1_r_q    <= expand(bus.r_in);
            s1_g_q    <= expand(bus.g_in);
            s1_b_q    <= expand(bus.b_in);
            s1_mode_q <= mode_eff;
            s2_r_q    <= s1_r_q;
            s2_g_q    <= s1_g_q;
            s2_b_q    <= s1_b_q;
            s2_mode_q <= s1_mode_q;
            r_out_q   <= r_d;
            g_out_q   <= g_d;
            b_out_q   <= b_d;
        end
    end

    monochrome_pipe_luma #(
        .OUT_BITS (OUT_BITS)
    ) u_luma (
        .clk   (clk),
        .rst_n (rst_n),
        .r     (s1_r_q),
        .g     (s1_g_q),
        .b     (s1_b_q),
`ifdef MONOCHROME_DITHER_EN
        .dith  (s1_dith_q),
`endif
        .luma  (s2_luma)
    );

    // S3 mode mux; de_sr_q[1] is the de bit of the pixel now in S2.
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de_sr_q[1]) begin
            case (s2_mode_q)
                MODE_COLOUR: begin
                    r_d = s2_r_q;
                    g_d = s2_g_q;
                    b_d = s2_b_q;
                end
                MODE_GREEN: begin
                    g_d = s2_luma;
                end
                MODE_AMBER: begin
                    r_d = s2_luma;
                    g_d = s2_luma >> 1;
                end
                default: begin
                    r_d = s2_luma;
                    g_d = s2_luma;
                    b_d = s2_luma;
                end
            endcase
        end
    end

    assign bus.r_out    = r_out_q;
    assign bus.g_out    = g_out_q;
    assign bus.b_out    = b_out_q;
    assign bus.de_out   = de_sr_q[LATENCY-1];
    assign bus.hs_out   = hs_sr_q[LATENCY-1];
    assign bus.vs_out   = vs_sr_q[LATENCY-1];
    assign bus.mode_cur = mode_cur_q;

endmodule

// File: tb/tb_monochrome_pipe.sv
// tb_monochrome_pipe: directed bench for monochrome_pipe (IN_BITS=3, OUT_BITS=6).
// Expected values are hand-computed: expansion 3->6 bits replicates the
// channel twice, luma = (38r + 75g + 15b) >> 7.
module tb_monochrome_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    monochrome_pipe_if #(.IN_BITS(3), .OUT_BITS(6)) bus ();

    monochrome_pipe #(
        .IN_BITS  (3),
        .OUT_BITS (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
        bus.de_in = de;
        bus.hs_in = hs;
        bus.vs_in = vs;
        bus.r_in  = r;
        bus.g_in  = g;
        bus.b_in  = b;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input int r, input int g, input int b);
        check({tag, ".r"}, 32'(bus.r_out), r);
        check({tag, ".g"}, 32'(bus.g_out), g);
        check({tag, ".b"}, 32'(bus.b_out), b);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.mode_req = 2'b00;
        drive(0, 0, 0, 0, 0, 0);

        // Reset with random inputs.
        for (int i = 0; i < 6; i++) begin
            bus.mode_req = 2'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end
        check_rgb("rst", 0, 0, 0);
        check("rst.de", 32'(bus.de_out), 0);
        check("rst.hs", 32'(bus.hs_out), 0);
        check("rst.vs", 32'(bus.vs_out), 0);
        check("rst.mode", 32'(bus.mode_cur), 0);

        // First pixel after reset: 5,2,7 -> 45,18,63 after exactly 3 clocks.
        rst_n        = 1'b1;
        bus.mode_req = 2'b00;
        drive(1, 0, 0, 5, 2, 7);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("first.lat2.r", 32'(bus.r_out), 0);
        check("first.lat2.de", 32'(bus.de_out), 0);
        tick();
        check_rgb("first", 45, 18, 63);
        check("first.de", 32'(bus.de_out), 1);

        // White mode via vs rise; later mode_req change is ignored.
        bus.mode_req = 2'b11;
        drive(0, 0, 1, 0, 0, 0);
        tick();
        bus.mode_req = 2'b00;
        check("white.mode", 32'(bus.mode_cur), 3);
        drive(1, 0, 0, 7, 7, 7);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("white.lat2.r", 32'(bus.r_out), 0);
        tick();
        check_rgb("white.777", 63, 63, 63);
        tick();
        check_rgb("white.000", 0, 0, 0);
        check("white.000.de", 32'(bus.de_out), 1);
        check("white.hold", 32'(bus.mode_cur), 3);

        // Green: 7,0,0 -> 63,0,0 -> luma 2394>>7 = 18.
        bus.mode_req = 2'b01;
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_rgb("green", 0, 18, 0);
        check("green.mode", 32'(bus.mode_cur), 1);

        // Amber: {18, 9, 0}.
        bus.mode_req = 2'b10;
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_rgb("amber", 18, 9, 0);

        // Back to colour.
        bus.mode_req = 2'b00;
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("colour.mode", 32'(bus.mode_cur), 0);

        // Mid-line request is ignored; the vs-rise pixel switches to white.
        // 45,18,63 -> 1710+1350+945 = 4005 -> luma 31.
        bus.mode_req = 2'b11;
        drive(1, 0, 0, 5, 2, 7);
        tick();
        drive(1, 0, 1, 5, 2, 7);
        tick();
        drive(1, 0, 1, 5, 2, 7);
        tick();
        check_rgb("mid.p1", 45, 18, 63);
        check("mid.p1.vs", 32'(bus.vs_out), 0);
        check("mid.mode", 32'(bus.mode_cur), 3);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_rgb("mid.p2", 31, 31, 31);
        check("mid.p2.vs", 32'(bus.vs_out), 1);
        tick();
        check_rgb("mid.p3", 31, 31, 31);

        // Blanked pixel in white mode, hs alignment.
        drive(0, 1, 0, 7, 7, 7);
        tick();
        drive(0, 0, 0, 7, 7, 7);
        tick();
        check("blank.lat2.hs", 32'(bus.hs_out), 0);
        tick();
        check_rgb("blank", 0, 0, 0);
        check("blank.hs", 32'(bus.hs_out), 1);
        check("blank.de", 32'(bus.de_out), 0);
        tick();
        check("blank.hs.after", 32'(bus.hs_out), 0);

        // 1,1,1 -> 9,9,9 -> sum 1152 -> luma 9 at every pixel.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1, 0, 0, 1, 1, 1);
            else       drive(0, 0, 0, 0, 0, 0);
            tick();
            if (i >= 2) check_rgb($sformatf("ones.%0d", i - 2), 9, 9, 9);
        end

        // Full scale 7,7,7 in white: sum 8064 stays at 63.
        drive(1, 0, 0, 7, 7, 7);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check_rgb("sat.0", 63, 63, 63);
        tick();
        check_rgb("sat.1", 63, 63, 63);

        // Reset mid-line with a coinciding vs rise: reset wins.
        drive(1, 0, 0, 7, 0, 0);
        tick();
        tick();
        rst_n        = 1'b0;
        bus.mode_req = 2'b10;
        drive(1, 0, 1, 7, 0, 0);
        tick();
        check_rgb("midrst", 0, 0, 0);
        check("midrst.de", 32'(bus.de_out), 0);
        check("midrst.mode", 32'(bus.mode_cur), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("flush.r", 32'(bus.r_out), 0);
        check("flush.de", 32'(bus.de_out), 0);
        drive(1, 0, 0, 7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("post.lat2.r", 32'(bus.r_out), 0);
        tick();
        check_rgb("post", 63, 0, 0);
        check("post.de", 32'(bus.de_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
